aoi222_resp_checker: RTL and testbench
======================================

// Module: aoi222_resp_checker
// PURPOSE
//  Self-checking response end for AOI222 cell characterisation: consumes (stimulus, ZN) samples from a
//  stimulus driver over a valid/ready stream, compares ZN against golden ~((A1&A2)|(B1&B2)|(C1&C2)),
//  counts mismatches, tracks coverage of all 64 input vectors, reports done/pass. Sits beside the cell
//  under test in gate-level regressions, replacing manual inspection of printed truth tables.
// PARAMETERS
//  ERR_W     8   width of mismatch counter (saturating)
//  VEC_W     6   stimulus width; fixed at 6 for AOI222 (A1,A2,B1,B2,C1,C2)
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst_n      in   1      synchronous active-low reset
//  start      in   1      pulse: clear counters/coverage, enter RUN
//  s_valid    in   1      sample valid
//  s_ready    out  1      checker ready; 1 only in RUN
//  s_stim     in   6      [5]=A1 [4]=A2 [3]=B1 [2]=B2 [1]=C1 [0]=C2
//  s_zn       in   1      sampled cell output for s_stim
//  mismatch   out  1      1-cycle pulse, registered, for a failing accepted sample
//  err_cnt    out  ERR_W  mismatch count, saturates at all-ones
//  cov_cnt    out  7      distinct vectors seen, 0..64
//  done       out  1      high in DONE
//  pass       out  1      done & (err_cnt==0)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE; s_ready=0, mismatch=0, err_cnt=0, cov_cnt=0, done=0, pass=0,
//    64-bit coverage map cleared. Reset overrides start and any in-flight sample.
//  - FSM: IDLE -start-> RUN; RUN -(cov_cnt reaches 64)-> DONE; DONE -start-> RUN; start in RUN
//    restarts RUN with cleared counters/map. start has priority over a same-cycle transfer (sample dropped).
//  - Transfer = s_valid & s_ready. s_ready is registered state, not dependent on s_valid.
//  - Per transfer: exp=~((s[5]&s[4])|(s[3]&s[2])|(s[1]&s[0])); if s_zn!=exp then mismatch=1 next cycle
//    and err_cnt+1 (hold at 2^ERR_W-1). X/Z on s_zn counts as mismatch (compare with !==).
//  - Coverage: map[s_stim] set on transfer; cov_cnt increments only on first visit of a vector.
//    Repeated vectors are still checked and may increment err_cnt.
//  - Latency: mismatch/err_cnt/cov_cnt update on edge after transfer (1 cycle). When the 64th distinct
//    vector transfers, cov_cnt=64, state=DONE, s_ready=0, done=1 all on the following edge.
//  - DONE: counters frozen, s_ready=0; pass valid. Samples in IDLE/DONE are not accepted.
// CONFIGURATION
//  - AOI_CHK_FIRST_FAIL_EN defined: adds outputs ff_valid(1), ff_stim(6), ff_zn(1); first mismatching
//    sample of a run captured (ff_valid=1, same cycle as mismatch), held until start/reset clears to 0.
//  - Not defined: ports absent, no capture registers; all other behaviour identical.
// TESTING
//  1 Reset mid-RUN after 10 vectors -> all outputs 0, IDLE, s_ready=0; start -> cov_cnt restarts at 0.
//  2 Ideal cell, vectors 0..63 in order, s_valid held 1 -> err_cnt=0, cov_cnt=64, done=1, pass=1,
//    s_ready=0 one cycle after vector 63.
//  3 Inject s_zn=1 for stim 6'b110000 (exp 0) -> one mismatch pulse, err_cnt=1, pass=0 at done;
//    with AOI_CHK_FIRST_FAIL_EN ff_stim=6'h30, ff_zn=1.
//  4 Send vector 6'h00 five times then 0..62 -> cov_cnt=63, done=0, s_ready=1; send 6'h3F -> done.
//  5 ERR_W=2, 5 failing samples -> err_cnt saturates at 3.
//  6 start coincident with a valid transfer in RUN -> sample dropped, counters 0; random s_valid gaps
//    -> no transfer lost/duplicated, cov_cnt=64 at end.

Source files
------------

// File: rtl/aoi222_resp_checker.sv
// ----------------------------------------------------------------------------
// aoi222_resp_checker
// Response checker for AOI222 cell characterisation. Accepts (stimulus, ZN)
// samples over a valid/ready stream. It compares each ZN against the golden
// value ~((A1&A2)|(B1&B2)|(C1&C2)) and keeps a saturating mismatch counter.
// It also tracks which of the 64 input vectors have been seen. Once all 64
// have been seen it reports done and pass.
//
// Optional feature: define AOI_CHK_FIRST_FAIL_EN to add ff_valid / ff_stim /
// ff_zn. These outputs capture the first mismatching sample of a run.
// ----------------------------------------------------------------------------
module aoi222_resp_checker #(
    parameter int ERR_W = 8,
    parameter int VEC_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [VEC_W-1:0] s_stim,
    input  logic             s_zn,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt,
    output logic [6:0]       cov_cnt,
    output logic             done,
    output logic             pass
`ifdef AOI_CHK_FIRST_FAIL_EN
    ,
    output logic             ff_valid,
    output logic [VEC_W-1:0] ff_stim,
    output logic             ff_zn
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    // Golden AOI222 response for stimulus {A1,A2,B1,B2,C1,C2}
    function automatic logic aoi222_golden(input logic [5:0] v);
        return ~((v[5] & v[4]) | (v[3] & v[2]) | (v[1] & v[0]));
    endfunction

    state_t             state_q, state_d;
    logic               mismatch_q, mismatch_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [6:0]         cov_cnt_q, cov_cnt_d;
    logic [63:0]        cov_map_q, cov_map_d;

    logic               s_ready_s;
    logic               done_s;
    logic               pass_s;
    logic               xfer_s;
    logic               exp_s;
    logic               fail_s;
    logic               new_vec_s;

    // Transfer qualification: start wins over a same-cycle sample, dropping it
    always_comb begin
        xfer_s    = s_valid & s_ready_s & ~start;
        exp_s     = aoi222_golden(s_stim);
        // X/Z on ZN must count as a failure, hence the case-inequality
        fail_s    = xfer_s & (s_zn !== exp_s);
        new_vec_s = xfer_s & ~cov_map_q[s_stim];
    end

    // FSM next-state: IDLE -> RUN on start, RUN -> DONE on the 64th new vector
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (start)                                  state_d = ST_RUN;
                else if (new_vec_s && cov_cnt_q == 7'd63)   state_d = ST_DONE;
                else                                        state_d = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from registered state, independent of s_valid
    always_comb begin
        s_ready_s = (state_q == ST_RUN);
        done_s    = (state_q == ST_DONE);
        pass_s    = (state_q == ST_DONE) && (err_cnt_q == {ERR_W{1'b0}});
    end

    // Checker datapath: mismatch pulse, saturating error count, coverage map
    always_comb begin
        mismatch_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        cov_cnt_d  = cov_cnt_q;
        cov_map_d  = cov_map_q;
        if (start) begin
            err_cnt_d = {ERR_W{1'b0}};
            cov_cnt_d = 7'd0;
            cov_map_d = 64'd0;
        end else begin
            mismatch_d = fail_s;
            if (fail_s && (err_cnt_q != ERR_MAX)) begin
                err_cnt_d = err_cnt_q + ERR_ONE;
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (new_vec_s) begin
                cov_map_d[s_stim] = 1'b1;
                cov_cnt_d         = cov_cnt_q + 7'd1;
            end else begin
                cov_cnt_d = cov_cnt_q;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mismatch_q <= 1'b0;
            err_cnt_q  <= {ERR_W{1'b0}};
            cov_cnt_q  <= 7'd0;
            cov_map_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
            cov_cnt_q  <= cov_cnt_d;
            cov_map_q  <= cov_map_d;
        end
    end

    assign s_ready  = s_ready_s;
    assign mismatch = mismatch_q;
    assign err_cnt  = err_cnt_q;
    assign cov_cnt  = cov_cnt_q;
    assign done     = done_s;
    assign pass     = pass_s;

`ifdef AOI_CHK_FIRST_FAIL_EN
    logic             ff_valid_q, ff_valid_d;
    logic [VEC_W-1:0] ff_stim_q,  ff_stim_d;
    logic             ff_zn_q,    ff_zn_d;

    // First-fail capture: latch the first failing sample of a run, clear on start
    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_stim_d  = ff_stim_q;
        ff_zn_d    = ff_zn_q;
        if (start) begin
            ff_valid_d = 1'b0;
            ff_stim_d  = {VEC_W{1'b0}};
            ff_zn_d    = 1'b0;
        end else if (fail_s && !ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_stim_d  = s_stim;
            ff_zn_d    = s_zn;
        end else begin
            ff_valid_d = ff_valid_q;
        end
    end

    // First-fail registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff_valid_q <= 1'b0;
            ff_stim_q  <= {VEC_W{1'b0}};
            ff_zn_q    <= 1'b0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_stim_q  <= ff_stim_d;
            ff_zn_q    <= ff_zn_d;
        end
    end

    assign ff_valid = ff_valid_q;
    assign ff_stim  = ff_stim_q;
    assign ff_zn    = ff_zn_q;
`endif

endmodule

// File: tb/tb_aoi222_resp_checker.sv
// ----------------------------------------------------------------------------
// tb_aoi222_resp_checker
// Randomised and directed bench for aoi222_resp_checker. A behavioural model
// is built from a seen-vector array and integer counters. It predicts every
// output after each clock edge. A second instance with ERR_W=2 exercises
// saturation of the error counter. Define AOI_CHK_FIRST_FAIL_EN to also
// check the first-fail capture outputs.
// ----------------------------------------------------------------------------
module tb_aoi222_resp_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       s_valid;
    logic [5:0] s_stim;
    logic       s_zn;

    logic       s_ready,  s_ready2;
    logic       mismatch, mismatch2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;
    logic [6:0] cov_cnt,  cov_cnt2;
    logic       done,     done2;
    logic       pass,     pass2;
`ifdef AOI_CHK_FIRST_FAIL_EN
    logic       ff_valid, ff_valid2;
    logic [5:0] ff_stim,  ff_stim2;
    logic       ff_zn,    ff_zn2;
`endif

    aoi222_resp_checker #(.ERR_W(8), .VEC_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid),
        .s_ready(s_ready), .s_stim(s_stim), .s_zn(s_zn),
        .mismatch(mismatch), .err_cnt(err_cnt), .cov_cnt(cov_cnt),
        .done(done), .pass(pass)
`ifdef AOI_CHK_FIRST_FAIL_EN
        , .ff_valid(ff_valid), .ff_stim(ff_stim), .ff_zn(ff_zn)
`endif
    );

    aoi222_resp_checker #(.ERR_W(2), .VEC_W(6)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid),
        .s_ready(s_ready2), .s_stim(s_stim), .s_zn(s_zn),
        .mismatch(mismatch2), .err_cnt(err_cnt2), .cov_cnt(cov_cnt2),
        .done(done2), .pass(pass2)
`ifdef AOI_CHK_FIRST_FAIL_EN
        , .ff_valid(ff_valid2), .ff_stim(ff_stim2), .ff_zn(ff_zn2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit  m_seen [64];
    int  m_cov;
    int  m_err;
    int  m_err2;
    bit  m_run;
    bit  m_done;
    bit  m_mis;
    bit  m_ffv;
    int  m_ffs;
    bit  m_ffz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic gold(input logic [5:0] v);
        return !((v[5] && v[4]) || (v[3] && v[2]) || (v[1] && v[0]));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_seen[i] = 1'b0;
        m_cov  = 0;
        m_err  = 0;
        m_err2 = 0;
        m_mis  = 1'b0;
        m_ffv  = 1'b0;
        m_ffs  = 0;
        m_ffz  = 1'b0;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_step();
        bit fail;
        if (!rst_n) begin
            model_clear();
            m_run  = 1'b0;
            m_done = 1'b0;
        end else if (start) begin
            model_clear();
            m_run  = 1'b1;
            m_done = 1'b0;
        end else if (m_run && s_valid) begin
            fail  = (s_zn !== gold(s_stim));
            m_mis = fail;
            if (fail) begin
                if (m_err  < 255) m_err++;
                if (m_err2 < 3)   m_err2++;
                if (!m_ffv) begin
                    m_ffv = 1'b1;
                    m_ffs = int'(s_stim);
                    m_ffz = s_zn;
                end
            end
            if (!m_seen[s_stim]) begin
                m_seen[s_stim] = 1'b1;
                m_cov++;
                if (m_cov == 64) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else begin
            m_mis = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("s_ready",  s_ready,  m_run);
        check("mismatch", mismatch, m_mis);
        check("err_cnt",  err_cnt,  m_err);
        check("cov_cnt",  cov_cnt,  m_cov);
        check("done",     done,     m_done);
        check("pass",     pass,     m_done && (m_err == 0));
        check("err_cnt2", err_cnt2, m_err2);
`ifdef AOI_CHK_FIRST_FAIL_EN
        check("ff_valid", ff_valid, m_ffv);
        if (m_ffv) begin
            check("ff_stim", ff_stim, m_ffs);
            check("ff_zn",   ff_zn,   m_ffz);
        end else begin
            check("ff_stim_clr", ff_stim, 0);
        end
`endif
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare
    task automatic cyc(input logic rst_v, input logic st_v, input logic v_v,
                       input logic [5:0] stim_v, input logic zn_v);
        rst_n   = rst_v;
        start   = st_v;
        s_valid = v_v;
        s_stim  = stim_v;
        s_zn    = zn_v;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send(input logic [5:0] v, input logic zn_v);
        cyc(1'b1, 1'b0, 1'b1, v, zn_v);
    endtask

    initial begin
        logic [5:0] sv;
        logic       zv;
        model_clear();
        m_run  = 1'b0;
        m_done = 1'b0;

        // Reset, plus reset overriding start
        cyc(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
        check("rst_ready", s_ready, 1'b0);
        check("rst_cov",   cov_cnt, 7'd0);
        cyc(1'b1, 1'b0, 1'b1, 6'd5, 1'b0);          // IDLE: not accepted

        // 1: reset mid-RUN after 10 vectors
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 10; i++) send(6'(i), gold(6'(i)));
        check("t1_cov10", cov_cnt, 7'd10);
        cyc(1'b0, 1'b0, 1'b1, 6'd20, 1'b1);
        check("t1_rst_cov", cov_cnt, 7'd0);
        check("t1_rst_rdy", s_ready, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        send(6'd33, gold(6'd33));
        check("t1_restart_cov", cov_cnt, 7'd1);

        // 2: ideal cell, 0..63 back to back
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 64; i++) send(6'(i), gold(6'(i)));
        check("t2_done", done, 1'b1);
        check("t2_pass", pass, 1'b1);
        check("t2_rdy",  s_ready, 1'b0);
        send(6'h30, 1'b1);                            // DONE: ignored
        check("t2_frozen_err", err_cnt, 8'd0);

        // 3: single injected fault at 6'h30
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            sv = 6'(i);
            send(sv, (sv == 6'h30) ? 1'b1 : gold(sv));
            if (sv == 6'h30) check("t3_pulse", mismatch, 1'b1);
        end
        check("t3_err",  err_cnt, 8'd1);
        check("t3_pass", pass, 1'b0);
        check("t3_done", done, 1'b1);

        // 4: repeats then 0..62, then the missing vector
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 5; i++) send(6'h00, gold(6'h00));
        for (int i = 0; i < 63; i++) send(6'(i), gold(6'(i)));
        check("t4_cov63", cov_cnt, 7'd63);
        check("t4_done0", done, 1'b0);
        check("t4_rdy1",  s_ready, 1'b1);
        send(6'h3F, gold(6'h3F));
        check("t4_done1", done, 1'b1);

        // 5: five failures, narrow counter saturates at 3
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
        for (int i = 0; i < 5; i++) send(6'h01, ~gold(6'h01));
        check("t5_err8", err_cnt, 8'd5);
        check("t5_err2", err_cnt2, 2'd3);
        send(6'h02, 1'bx);                            // X counts as a failure
        check("t5_x_err", err_cnt, 8'd6);

        // 6: start with a same-cycle valid sample drops it
        cyc(1'b1, 1'b1, 1'b1, 6'h30, 1'b1);
        check("t6_drop_cov", cov_cnt, 7'd0);
        check("t6_drop_err", err_cnt, 8'd0);
        for (int i = 0; i < 6000 && !m_done; i++) begin
            sv = 6'($urandom);
            zv = gold(sv);
            if ($urandom_range(0, 15) == 0) zv = ~zv;
            cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), sv, zv);
        end
        check("t6_done", done, 1'b1);
        check("t6_cov",  cov_cnt, 7'd64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
